// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator (bars, checker, gradient, bouncing box); button cycles the pattern.
// Latency 2 clocks from pixel/sync inputs to RGB/sync outputs; no backpressure, free-running pixel stream.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BOX        = 32,
    parameter int DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] h_pixel,
    input  logic [9:0]  v_pixel,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        mode_btn,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [1:0]  mode,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIMIT = 10'(V_ACTIVE);
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BOX);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BOX);
    localparam logic [11:0] BOX_W   = 12'(BOX);
    localparam logic [10:0] BOX_H   = 11'(BOX);
    localparam int          CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    logic [10:0]   h_s1;
    logic [9:0]    v_s1;
    logic          act_s1;
    logic          hs_s1;
    logic          vs_s1;

    logic [2:0]    bar;
    logic          in_box;
    logic [3:0]    pix_r;
    logic [3:0]    pix_g;
    logic [3:0]    pix_b;

    logic          frame_tick;
    logic [10:0]   box_x;
    logic [9:0]    box_y;
    logic          dir_x_left;
    logic          dir_y_up;

    logic          btn_meta;
    logic          btn_sync;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] deb_cnt_nxt;
    logic          mode_inc;

    // Stage 1: capture the pixel coordinate, its visibility and the syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_s1   <= '0;
            v_s1   <= '0;
            act_s1 <= 1'b0;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
        end else begin
            h_s1   <= h_pixel;
            v_s1   <= v_pixel;
            act_s1 <= (h_pixel < H_LIMIT) && (v_pixel < V_LIMIT);
            hs_s1  <= hsync;
            vs_s1  <= vsync;
        end
    end

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_s1 >= 11'((k * H_ACTIVE) / 8)) begin
                bar = 3'(k);
            end
        end
    end

    assign in_box = (h_s1 >= box_x) && ({1'b0, h_s1} < ({1'b0, box_x} + BOX_W)) &&
                    (v_s1 >= box_y) && ({1'b0, v_s1} < ({1'b0, box_y} + BOX_H));

    // Pattern is chosen with the live mode so a button press shows on the very next pixel.
    always_comb begin
        pix_r = 4'h0;
        pix_g = 4'h0;
        pix_b = 4'h0;
        case (mode)
            2'd0: begin
                pix_r = {4{bar[2]}};
                pix_g = {4{bar[1]}};
                pix_b = {4{bar[0]}};
            end
            2'd1: begin
                if (h_s1[5] ^ v_s1[5]) begin
                    pix_r = 4'hF;
                    pix_g = 4'hF;
                    pix_b = 4'hF;
                end
            end
            2'd2: begin
                pix_r = h_s1[9:6];
                pix_g = v_s1[8:5];
            end
            default: begin
                if (in_box) begin
                    pix_r = 4'hF;
                    pix_g = 4'hF;
                    pix_b = 4'hF;
                end else begin
                    pix_b = 4'h8;
                end
            end
        endcase
        if (!act_s1) begin
            pix_r = 4'h0;
            pix_g = 4'h0;
            pix_b = 4'h0;
        end
    end

    // Stage 2: registered colour with the syncs kept in step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red       <= 4'h0;
            green     <= 4'h0;
            blue      <= 4'h0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            red       <= pix_r;
            green     <= pix_g;
            blue      <= pix_b;
            hsync_out <= hs_s1;
            vsync_out <= vs_s1;
        end
    end

    // Falling edge of the stage-1 vsync, seen against its stage-2 copy.
    assign frame_tick = vsync_out & ~vs_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_x      <= '0;
            box_y      <= '0;
            dir_x_left <= 1'b0;
            dir_y_up   <= 1'b0;
        end else if (frame_tick) begin
            if (!dir_x_left) begin
                if (box_x == X_MAX) begin
                    dir_x_left <= 1'b1;
                    box_x      <= box_x - 11'd1;
                end else begin
                    box_x <= box_x + 11'd1;
                end
            end else begin
                if (box_x == 11'd0) begin
                    dir_x_left <= 1'b0;
                    box_x      <= 11'd1;
                end else begin
                    box_x <= box_x - 11'd1;
                end
            end
            if (!dir_y_up) begin
                if (box_y == Y_MAX) begin
                    dir_y_up <= 1'b1;
                    box_y    <= box_y - 10'd1;
                end else begin
                    box_y <= box_y + 10'd1;
                end
            end else begin
                if (box_y == 10'd0) begin
                    dir_y_up <= 1'b0;
                    box_y    <= 10'd1;
                end else begin
                    box_y <= box_y - 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= mode_btn;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
        end
    end

    // Debounce: a press must stay high for DEB_CYCLES clocks; HELD blocks auto-repeat.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        mode_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_sync) begin
                    state_nxt   = S_WAIT;
                    deb_cnt_nxt = '0;
                end
            end
            S_WAIT: begin
                if (!btn_sync) begin
                    state_nxt   = S_IDLE;
                    deb_cnt_nxt = '0;
                end else if (deb_cnt == CNT_MAX) begin
                    state_nxt = S_HELD;
                    mode_inc  = 1'b1;
                end else begin
                    deb_cnt_nxt = deb_cnt + CW'(1);
                end
            end
            S_HELD: begin
                if (!btn_sync) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                deb_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= 2'd0;
        end else if (mode_inc) begin
            mode <= mode + 2'd1;
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 SHALL have parameter BOX, default 32: side length of the bouncing box, in pixels.
REQ-004 SHALL have parameter DEB_CYCLES, default 250000: clocks the button must stay stable high (10 ms at 25 MHz).
REQ-005 SHALL have port clk, input, 1 bit: pixel clock, rising edge; the same clock as the timing generator.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port h_pixel, input, 11 bits: horizontal pixel count from the timing generator.
REQ-008 SHALL have port v_pixel, input, 10 bits: vertical line count from the timing generator.
REQ-009 SHALL have ports hsync and vsync, input, 1 bit each: syncs from the timing generator, active-low.
REQ-010 SHALL have port mode_btn, input, 1 bit: raw asynchronous push-button, active-high.
REQ-011 SHALL have ports red, green and blue, output, 4 bits each: pixel colour, registered.
REQ-012 SHALL have ports hsync_out and vsync_out, output, 1 bit each: syncs delayed to align with RGB, registered.
REQ-013 SHALL have port mode, output, 2 bits: current pattern select.
REQ-014 SHALL have port frame_cnt, output, 8 bits: frame counter.

Function
REQ-015 SHALL treat a pixel as active iff h_pixel < H_ACTIVE and v_pixel < V_ACTIVE.
REQ-016 SHALL pipeline in two stages: stage 1 registers h, v, active, hsync and vsync; stage 2 registers RGB, hsync_out and vsync_out.
REQ-017 SHALL make total latency exactly 2 clocks from inputs to red/green/blue/hsync_out/vsync_out, with all five outputs aligned.
REQ-018 SHALL drive RGB = 0/0/0 whenever the stage-1 active flag is 0, in every mode.
REQ-019 SHALL implement mode 0 as colour bars: bar k covers h in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8 - 1] for k = 0..7; red = F if k[2] else 0, green = F if k[1] else 0, blue = F if k[0] else 0.
REQ-020 SHALL implement mode 1 as checkerboard: RGB = F/F/F if h[5] XOR v[5], else 0/0/0.
REQ-021 SHALL implement mode 2 as gradient: red = h[9:6], green = v[8:5], blue = 0.
REQ-022 SHALL implement mode 3 as bouncing box: RGB = F/F/F if box_x <= h < box_x+BOX and box_y <= v < box_y+BOX; otherwise RGB = 0/0/8.
REQ-023 SHALL generate frame_tick as a 1-clock pulse when registered vsync goes 1 -> 0.
REQ-024 SHALL increment frame_cnt on frame_tick, wrapping 255 -> 0.
REQ-025 SHALL update box_x and box_y only on frame_tick, in every mode.
REQ-026 SHALL step box_x by 1 in direction dir_x.
REQ-027 SHALL, if moving right and box_x == H_ACTIVE-BOX, set dir_x to left and box_x to box_x-1.
REQ-028 SHALL, if moving left and box_x == 0, set dir_x to right and box_x to 1.
REQ-029 SHALL move box_y and dir_y identically, using V_ACTIVE.
REQ-030 SHALL synchronise mode_btn through 2 flip-flops before any use.
REQ-031 SHALL implement a debounce FSM with states IDLE, WAIT and HELD.
REQ-032 SHALL, in IDLE, go to WAIT with the counter cleared when synced btn = 1.
REQ-033 SHALL, in WAIT, increment the counter while btn = 1, and return to IDLE with the counter cleared if btn = 0.
REQ-034 SHALL, in WAIT, go to HELD when the counter reaches DEB_CYCLES-1 with btn still 1, incrementing mode mod 4 (3 -> 0) exactly once.
REQ-035 SHALL, in HELD, stay until btn = 0, then go to IDLE; holding the button never advances mode again.
REQ-036 SHALL apply a mode change from the next stage-2 pixel onward, including mid-frame.
REQ-037 SHALL process frame_tick and a mode increment in the same clock independently, with both taking effect.

Reset
REQ-038 SHALL, on rst, asynchronously force: red/green/blue = 0; hsync_out = vsync_out = 1; all pipeline sync registers = 1; mode = 0; frame_cnt = 0.
REQ-039 SHALL, on rst, asynchronously force: box_x = box_y = 0; dir_x = right; dir_y = down; FSM = IDLE; debounce counter = 0; synchroniser flops = 0.
REQ-040 SHALL, if rst is asserted mid-frame or mid-debounce, abandon all progress; after release, operation resumes from reset values with no spurious mode increment.

Verification (DEB_CYCLES = 4)
REQ-041 SHALL verify: mode 0, h = 85, v = 10 -> 2 clocks later RGB = 0/0/F.
REQ-042 SHALL verify: mode 0, h = 700, v = 10 -> 2 clocks later RGB = 0/0/0, and an hsync 1 -> 0 edge appears on hsync_out exactly 2 clocks later.
REQ-043 SHALL verify: button pulse high for 2 clocks -> mode stays 0; button high for 20 clocks -> mode = 1 exactly once; 4 valid presses from mode 0 -> mode back to 0.
REQ-044 SHALL verify: mode 3 from reset, 608 frame_ticks -> box_x = 608 and dir_x = right; next tick -> box_x = 607 and dir_x = left; frame_cnt = 609 mod 256 = 97.
REQ-045 SHALL verify: 256 frame_ticks -> frame_cnt wraps to 0.
REQ-046 SHALL verify: rst asserted in WAIT after 2 counts with the button held -> mode = 0, FSM = IDLE; after release, with the button still held, exactly one increment after DEB_CYCLES.
